alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 17 +
 rtl/btn_sync_edge.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operand-loading sequencer: state codes and
// a helper that identifies the states in which the idle timer runs.
package alu_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        SHOW    = 2'd3
    } alu_state_t;

    // A partial load is only "in progress" once operand A has been taken.
    function automatic logic is_partial_load(input alu_state_t s);
        return (s == LOAD_B) || (s == LOAD_OP);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the raw push-button plus rising-edge detector.
// All flops reset high so a button held through reset release never
// produces a press.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    logic r_s1;
    logic r_s2;
    logic r_s2_prev;

    // Synchronise the button and keep one cycle of history for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_s2_prev <= 1'b1;
        end else begin
            r_s1      <= i_btn;
            r_s2      <= r_s1;
            r_s2_prev <= r_s2;
        end
    end

    assign o_press = r_s2 & ~r_s2_prev;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Button-driven sequencer that loads operand A, operand B and the opcode
// from a shared switch bus into external registers, then shows the result.
// Optional idle timeout on partial loads: define ALU_CTRL_TIMEOUT_EN.
//
// state   | meaning
// LOAD_A  | waiting for press to capture operand A
// LOAD_B  | waiting for press to capture operand B
// LOAD_OP | waiting for press to capture the opcode
// SHOW    | operands complete, ALU result valid; press clears and restarts
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH          = 5,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_next,
    input  logic             cancel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] reg_d,
    output logic             load_a,
    output logic             load_b,
    output logic             load_op,
    output logic             clr_o,
    output logic [1:0]       state_o,
    output logic             result_valid,
    output logic             timeout_o
);

    alu_state_t       r_state;
    alu_state_t       w_next_state;
    logic [WIDTH-1:0] r_reg_d;
    logic             r_load_a;
    logic             r_load_b;
    logic             r_load_op;
    logic             r_clr;
    logic             w_load_a;
    logic             w_load_b;
    logic             w_load_op;
    logic             w_clr;
    logic             w_press;
    logic             w_timeout_hit;

    btn_sync_edge u_btn_sync_edge (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_next),
        .o_press (w_press)
    );

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_timeout;
    logic             w_idle_state;

    assign w_idle_state  = is_partial_load(r_state);
    assign w_timeout_hit = w_idle_state && (r_idle_cnt == CNT_LAST);

    // Idle counter: runs only during a partial load, restarts on any activity.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (!w_idle_state || w_press || (w_next_state != r_state)) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Timeout pulse; cancel in the same cycle wins, so no pulse then.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit && !cancel;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    // Next-state and strobe decode: cancel beats timeout beats press.
    always_comb begin
        w_next_state = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_clr        = 1'b0;
        if (cancel) begin
            w_next_state = LOAD_A;
            w_clr        = 1'b1;
        end else if (w_timeout_hit) begin
            w_next_state = LOAD_A;
            w_clr        = 1'b1;
        end else if (w_press) begin
            case (r_state)
                LOAD_A: begin
                    w_next_state = LOAD_B;
                    w_load_a     = 1'b1;
                end
                LOAD_B: begin
                    w_next_state = LOAD_OP;
                    w_load_b     = 1'b1;
                end
                LOAD_OP: begin
                    w_next_state = SHOW;
                    w_load_op    = 1'b1;
                end
                SHOW: begin
                    w_next_state = LOAD_A;
                    w_clr        = 1'b1;
                end
                default: begin
                    w_next_state = LOAD_A;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered strobes and data; reg_d only moves on a load edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_reg_d   <= '0;
            r_load_a  <= 1'b0;
            r_load_b  <= 1'b0;
            r_load_op <= 1'b0;
            r_clr     <= 1'b0;
        end else begin
            r_load_a  <= w_load_a;
            r_load_b  <= w_load_b;
            r_load_op <= w_load_op;
            r_clr     <= w_clr;
            if (w_load_a || w_load_b || w_load_op) begin
                r_reg_d <= data_in;
            end
        end
    end

    assign reg_d        = r_reg_d;
    assign load_a       = r_load_a;
    assign load_b       = r_load_b;
    assign load_op      = r_load_op;
    assign clr_o        = r_clr;
    assign state_o      = r_state;
    assign result_valid = (r_state == SHOW);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl. Build with ALU_CTRL_TIMEOUT_EN defined
// to exercise the idle timeout; expectations follow the same macro.
module tb_alu_seq_ctrl;

    logic       clock;
    logic       reset;
    logic       btn_next;
    logic       cancel;
    logic [4:0] data_in;
    logic [4:0] reg_d;
    logic       load_a;
    logic       load_b;
    logic       load_op;
    logic       clr_o;
    logic [1:0] state_o;
    logic       result_valid;
    logic       timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(
        .WIDTH          (5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_next     (btn_next),
        .cancel       (cancel),
        .data_in      (data_in),
        .reg_d        (reg_d),
        .load_a       (load_a),
        .load_b       (load_b),
        .load_op      (load_op),
        .clr_o        (clr_o),
        .state_o      (state_o),
        .result_valid (result_valid),
        .timeout_o    (timeout_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {load_a, load_b, load_op, clr_o, timeout_o}
    function automatic logic [31:0] strb();
        return 32'({load_a, load_b, load_op, clr_o, timeout_o});
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clean press: strobe must appear on the third edge only, then data holds.
    task automatic do_press(input string tag, input logic [4:0] d, input logic [4:0] exp_strb,
                            input logic [1:0] exp_state, input logic [4:0] exp_regd);
        @(negedge clock);
        data_in  = d;
        btn_next = 1'b1;
        tick();
        chk({tag, "_e1_strb"}, strb(), 32'h0);
        tick();
        chk({tag, "_e2_strb"}, strb(), 32'h0);
        tick();
        chk({tag, "_e3_strb"}, strb(), 32'(exp_strb));
        chk({tag, "_e3_state"}, 32'(state_o), 32'(exp_state));
        chk({tag, "_e3_regd"}, 32'(reg_d), 32'(exp_regd));
        chk({tag, "_e3_rv"}, 32'(result_valid), (exp_state == 2'd3) ? 32'h1 : 32'h0);
        tick();
        chk({tag, "_e4_strb"}, strb(), 32'h0);
        @(negedge clock);
        btn_next = 1'b0;
        data_in  = ~d;
        repeat (4) tick();
        chk({tag, "_hold_regd"}, 32'(reg_d), 32'(exp_regd));
        chk({tag, "_hold_state"}, 32'(state_o), 32'(exp_state));
    endtask

    initial begin
        int n_strb;
        int first_at;

        reset    = 1'b1;
        btn_next = 1'b1;
        cancel   = 1'b0;
        data_in  = 5'h00;

        // Reset values, with the button already held down.
        repeat (3) tick();
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_regd", 32'(reg_d), 32'h0);
        chk("rst_strb", strb(), 32'h0);
        chk("rst_rv", 32'(result_valid), 32'h0);

        // Button held across reset release must not count as a press.
        @(negedge clock);
        reset  = 1'b0;
        n_strb = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (strb() != 32'h0) n_strb++;
        end
        chk("held_rst_nstrb", 32'(n_strb), 32'h0);
        chk("held_rst_state", 32'(state_o), 32'h0);
        @(negedge clock);
        btn_next = 1'b0;
        repeat (4) tick();

        // Full load sequence A, B, opcode.
        do_press("ldA", 5'h0A, 5'b10000, 2'd1, 5'h0A);
        do_press("ldB", 5'h03, 5'b01000, 2'd2, 5'h03);
        do_press("ldOP", 5'h02, 5'b00100, 2'd3, 5'h02);

        // Press in SHOW clears and restarts with no load strobe.
        do_press("show_clr", 5'h1E, 5'b00010, 2'd0, 5'h02);

        // Walk to LOAD_OP, then hold the button for 100 cycles.
        do_press("ldA2", 5'h11, 5'b10000, 2'd1, 5'h11);
        do_press("ldB2", 5'h12, 5'b01000, 2'd2, 5'h12);
        @(negedge clock);
        data_in  = 5'h15;
        btn_next = 1'b1;
        n_strb   = 0;
        first_at = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (strb() != 32'h0) begin
                n_strb++;
                if (first_at == 0) first_at = i;
            end
        end
        chk("held100_nstrb", 32'(n_strb), 32'h1);
        chk("held100_edge", 32'(first_at), 32'h3);
        chk("held100_state", 32'(state_o), 32'h3);
        chk("held100_regd", 32'(reg_d), 32'h15);
        @(negedge clock);
        btn_next = 1'b0;
        repeat (4) tick();
        do_press("show_clr2", 5'h01, 5'b00010, 2'd0, 5'h15);

        // Cancel together with a press in LOAD_B: cancel wins, press dropped.
        do_press("ldA3", 5'h07, 5'b10000, 2'd1, 5'h07);
        @(negedge clock);
        data_in  = 5'h0C;
        btn_next = 1'b1;
        tick();
        tick();
        @(negedge clock);
        cancel = 1'b1;
        tick();
        chk("cxl_strb", strb(), 32'h2);
        chk("cxl_state", 32'(state_o), 32'h0);
        chk("cxl_regd", 32'(reg_d), 32'h07);
        @(negedge clock);
        cancel = 1'b0;
        tick();
        chk("cxl_e4_strb", strb(), 32'h0);
        @(negedge clock);
        btn_next = 1'b0;
        n_strb   = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (strb() != 32'h0) n_strb++;
        end
        chk("cxl_after_nstrb", 32'(n_strb), 32'h0);
        chk("cxl_after_state", 32'(state_o), 32'h0);

        // Idle in LOAD_B for 16 cycles.
        @(negedge clock);
        data_in  = 5'h09;
        btn_next = 1'b1;
        repeat (3) tick();
        chk("to_ld_strb", strb(), 32'h10);
        chk("to_ld_state", 32'(state_o), 32'h1);
        @(negedge clock);
        btn_next = 1'b0;
        n_strb   = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (strb() != 32'h0 && i > 1) n_strb++;
        end
        chk("to_quiet_nstrb", 32'(n_strb), 32'h0);
        tick();
`ifdef ALU_CTRL_TIMEOUT_EN
        chk("to_fire_strb", strb(), 32'h3);
        chk("to_fire_state", 32'(state_o), 32'h0);
        tick();
        chk("to_after_strb", strb(), 32'h0);
`else
        chk("to_none_strb", strb(), 32'h0);
        chk("to_none_state", 32'(state_o), 32'h1);
        tick();
        chk("to_none_state2", 32'(state_o), 32'h1);
`endif

        // Plain cancel returns to LOAD_A with a clear pulse.
        @(negedge clock);
        cancel = 1'b1;
        tick();
        chk("cancel_strb", strb(), 32'h2);
        chk("cancel_state", 32'(state_o), 32'h0);
        @(negedge clock);
        cancel = 1'b0;
        tick();

        // Reset mid-sequence abandons the load without a clear pulse.
        do_press("ldA4", 5'h1F, 5'b10000, 2'd1, 5'h1F);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("midrst_strb", strb(), 32'h0);
        chk("midrst_state", 32'(state_o), 32'h0);
        chk("midrst_regd", 32'(reg_d), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("midrst_after_strb", strb(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
